// File: rtl/left_shift_sequencer.sv
// Multi-cycle sequencer driving a combinational left-shift block once per step.
// Define LEFT_SHIFT_SEQ_STICKY_OF_EN to make rsp_of_o accumulate overflow over all steps.
module left_shift_sequencer #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [WORD_WIDTH-1:0] req_a_i,
    input  logic [WORD_WIDTH-1:0] req_b_i,
    input  logic [WORD_WIDTH-1:0] req_c_i,
    input  logic                  req_cf_i,
    input  logic [CNT_WIDTH-1:0]  req_cnt_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WORD_WIDTH-1:0] rsp_r_o,
    output logic                  rsp_cf_o,
    output logic                  rsp_zf_o,
    output logic                  rsp_of_o,
    output logic                  rsp_pf_o,
    output logic                  rsp_sf_o,
    output logic [1:0]            sh_op_o,
    output logic [WORD_WIDTH-1:0] sh_a_o,
    output logic [WORD_WIDTH-1:0] sh_b_o,
    output logic [WORD_WIDTH-1:0] sh_c_o,
    output logic                  sh_cf_o,
    input  logic [WORD_WIDTH-1:0] sh_r_i,
    input  logic                  sh_cf_i,
    input  logic                  sh_of_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [WORD_WIDTH-1:0] acc;
    logic                  carry;
    logic [1:0]            op;
    logic [WORD_WIDTH-1:0] b;
    logic [WORD_WIDTH-1:0] c;
    logic [CNT_WIDTH-1:0]  rem;
    logic                  ofacc;

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == DONE);

    assign sh_op_o = op;
    assign sh_a_o  = acc;
    assign sh_b_o  = b;
    assign sh_c_o  = c;
    assign sh_cf_o = carry;

    // Result flags derive straight from the registers so they hold under backpressure.
    assign rsp_r_o  = acc;
    assign rsp_cf_o = carry;
    assign rsp_of_o = ofacc;
    assign rsp_zf_o = ~|acc;
    assign rsp_pf_o = acc[0];
    assign rsp_sf_o = acc[WORD_WIDTH-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            acc   <= '0;
            carry <= 1'b0;
            op    <= '0;
            b     <= '0;
            c     <= '0;
            rem   <= '0;
            ofacc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op    <= req_op_i;
                        acc   <= req_a_i;
                        b     <= req_b_i;
                        c     <= req_c_i;
                        carry <= req_cf_i;
                        rem   <= req_cnt_i;
                        ofacc <= 1'b0;
                        state <= (req_cnt_i != '0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    acc   <= sh_r_i;
                    carry <= sh_cf_i;
                    rem   <= rem - CNT_WIDTH'(1);
`ifdef LEFT_SHIFT_SEQ_STICKY_OF_EN
                    ofacc <= ofacc | sh_of_i;
`else
                    ofacc <= sh_of_i;
`endif
                    if (rem == CNT_WIDTH'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_left_shift_sequencer.sv
// Bench for left_shift_sequencer with an 8-bit shift-block model.
// Honours LEFT_SHIFT_SEQ_STICKY_OF_EN for the expected overflow flag.
module tb_left_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] req_c;
    logic       req_cf;
    logic [5:0] req_cnt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_r;
    logic       rsp_cf;
    logic       rsp_zf;
    logic       rsp_of;
    logic       rsp_pf;
    logic       rsp_sf;
    logic [1:0] sh_op;
    logic [7:0] sh_a;
    logic [7:0] sh_b;
    logic [7:0] sh_c;
    logic       sh_cf_out;
    logic [7:0] sh_r;
    logic       sh_cf_in;
    logic       sh_of;

    int checks = 0;
    int failures = 0;

    logic [7:0] obs_r;
    logic       obs_cf;
    logic       obs_zf;
    logic       obs_of;
    logic       obs_pf;
    logic       obs_sf;

    always #5 clk = ~clk;

    left_shift_sequencer #(.WORD_WIDTH(8), .CNT_WIDTH(6)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i(req_op),
        .req_a_i(req_a),
        .req_b_i(req_b),
        .req_c_i(req_c),
        .req_cf_i(req_cf),
        .req_cnt_i(req_cnt),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_r_o(rsp_r),
        .rsp_cf_o(rsp_cf),
        .rsp_zf_o(rsp_zf),
        .rsp_of_o(rsp_of),
        .rsp_pf_o(rsp_pf),
        .rsp_sf_o(rsp_sf),
        .sh_op_o(sh_op),
        .sh_a_o(sh_a),
        .sh_b_o(sh_b),
        .sh_c_o(sh_c),
        .sh_cf_o(sh_cf_out),
        .sh_r_i(sh_r),
        .sh_cf_i(sh_cf_in),
        .sh_of_i(sh_of)
    );

    // Shift-block model: returns {of, cf, r}.
    function automatic logic [9:0] shf(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c,
                                       input logic cf);
        logic [7:0] r;
        case (op)
            2'b00:   r = a << 1;
            2'b01:   r = {a[6:0], cf};
            2'b10:   r = {a[6:0], b[0]};
            default: r = {a[6:0], c[7]};
        endcase
        return {r[7] ^ a[7], a[7], r};
    endfunction

    always_comb begin
        logic [9:0] t;
        t = shf(sh_op, sh_a, sh_b, sh_c, sh_cf_out);
        sh_r     = t[7:0];
        sh_cf_in = t[8];
        sh_of    = t[9];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_zf"}, 32'(rsp_zf), 32'd1);
        chk({tag, "_rsp_rest"}, {rsp_r, rsp_cf, rsp_of, rsp_pf, rsp_sf}, 32'd0);
        chk({tag, "_sh"}, {sh_op, sh_a, sh_b, sh_c, sh_cf_out}, 32'd0);
    endtask

    task automatic run_req(input string tag, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c, input logic cf,
                           input int cnt, input int hold, input logic busy_req);
        logic [7:0] er;
        logic       ec;
        logic       eo;
        logic [9:0] t;
        logic [7:0] prev;
        er = a;
        ec = cf;
        eo = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            t = shf(op, er, b, c, ec);
            er = t[7:0];
            ec = t[8];
`ifdef LEFT_SHIFT_SEQ_STICKY_OF_EN
            eo = eo | t[9];
`else
            eo = t[9];
`endif
        end
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_c = c;
        req_cf = cf;
        req_cnt = 6'(cnt);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        prev = a;
        for (int i = 0; i < cnt; i++) begin
            chk({tag, "_busy_valid"}, 32'(rsp_valid), 32'd0);
            chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
            chk({tag, "_busy_opbc"}, {sh_op, sh_b, sh_c}, {op, b, c});
            chk({tag, "_busy_a"}, 32'(sh_a), 32'(prev));
            if (i == 0) chk({tag, "_busy_cf0"}, 32'(sh_cf_out), 32'(cf));
            prev = sh_r;
            @(posedge clk);
            #1;
        end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_r"}, 32'(rsp_r), 32'(er));
        chk({tag, "_flags"}, {rsp_cf, rsp_zf, rsp_of, rsp_pf, rsp_sf},
            {ec, er == 8'h00, eo, er[0], er[7]});
        obs_r = rsp_r;
        obs_cf = rsp_cf;
        obs_zf = rsp_zf;
        obs_of = rsp_of;
        obs_pf = rsp_pf;
        obs_sf = rsp_sf;
        for (int h = 0; h < hold; h++) begin
            if (busy_req) begin
                req_valid = 1'b1;
                req_a = 8'hFF;
                req_cnt = 6'd1;
            end
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            chk({tag, "_hold_out"}, {rsp_r, rsp_cf, rsp_zf, rsp_of, rsp_pf, rsp_sf},
                {er, ec, er == 8'h00, eo, er[0], er[7]});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_after_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_after_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        req_cf = 1'b0;
        req_cnt = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_req("normal", 2'b00, 8'h01, 8'h00, 8'h00, 1'b0, 3, 0, 1'b0);
        chk("normal_r_const", 32'(obs_r), 32'h08);
        chk("normal_flags_const", {obs_cf, obs_zf, obs_pf, obs_sf, obs_of}, 32'd0);

        run_req("zero", 2'b00, 8'h80, 8'h00, 8'h00, 1'b1, 0, 0, 1'b0);
        chk("zero_r_const", 32'(obs_r), 32'h80);
        chk("zero_flags_const", {obs_cf, obs_sf, obs_zf, obs_of}, 32'b1100);

        run_req("ovf", 2'b00, 8'h60, 8'h00, 8'h00, 1'b0, 2, 0, 1'b0);
        chk("ovf_r_const", 32'(obs_r), 32'h80);
        chk("ovf_cf_sf_const", {obs_cf, obs_sf}, 32'b11);
`ifdef LEFT_SHIFT_SEQ_STICKY_OF_EN
        chk("ovf_of_const", 32'(obs_of), 32'd1);
`else
        chk("ovf_of_const", 32'(obs_of), 32'd0);
`endif

        run_req("bp", 2'b00, 8'h11, 8'h00, 8'h00, 1'b0, 2, 5, 1'b1);
        run_req("bp_next", 2'b00, 8'h22, 8'h00, 8'h00, 1'b1, 1, 0, 1'b0);

        run_req("stable", 2'b01, 8'h3C, 8'h5A, 8'hA5, 1'b1, 4, 0, 1'b0);

        req_valid = 1'b1;
        req_op = 2'b00;
        req_a = 8'h01;
        req_cf = 1'b0;
        req_cnt = 6'd5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy_pre", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        for (int n = 0; n < 25; n++) begin
            run_req("rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    8'($urandom), 1'($urandom), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/left_shift_sequencer.md
# left_shift_sequencer

Multi-cycle sequencer in front of the ALU left-shift datapath. It accepts one shift request (operation, operands, carry-in, step count) over a valid/ready handshake. It then drives the combinational left-shift block once per cycle, feeding each step's result and carry back as the next step's input, and returns the final result with ZF/CF/OF/PF/SF over a second valid/ready handshake. Only one request is in flight at a time.

## Interface
Parameters:
- WORD_WIDTH, default 32: datapath width, must match the attached shift block.
- CNT_WIDTH, default 6: width of the step-count field.

Ports (clk_i, rst_ni: one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready, high only in IDLE
- req_op_i  in  2  shift-block operation code
- req_a_i / req_b_i / req_c_i  in  WORD_WIDTH each  initial operands
- req_cf_i  in  1  initial carry-in
- req_cnt_i  in  CNT_WIDTH  number of shift steps, 0 allowed
- rsp_valid_o  out  1  result valid, high only in DONE
- rsp_ready_i  in  1  result accepted
- rsp_r_o  out  WORD_WIDTH  final result
- rsp_cf_o / rsp_zf_o / rsp_of_o / rsp_pf_o / rsp_sf_o  out  1 each  final flags
- sh_op_o  out  2  to shift block op_i
- sh_a_o / sh_b_o / sh_c_o  out  WORD_WIDTH each  to shift block a_i / b_i / c_i
- sh_cf_o  out  1  to shift block cf_i
- sh_r_i  in  WORD_WIDTH  from shift block r_o
- sh_cf_i / sh_of_i  in  1 each  from shift block cf_o / of_o

## Operation
- Registers:
  - acc, the running result.
  - carry.
  - op, b and c.
  - rem, the remaining-step count (CNT_WIDTH wide).
  - ofacc, the overflow accumulator.
  - state.
- sh_a_o = acc, sh_cf_o = carry, sh_op_o/sh_b_o/sh_c_o = op/b/c. These are driven from registers in every state.
- States: IDLE, BUSY, DONE.
- IDLE, on req_valid_i & req_ready_o:
  - Load op, acc=req_a_i, b, c, carry=req_cf_i, rem=req_cnt_i, ofacc=0.
  - Go to BUSY if req_cnt_i != 0, else to DONE.
- BUSY, every cycle:
  - acc <= sh_r_i, carry <= sh_cf_i, rem <= rem-1.
  - ofacc updated per Configuration.
  - When rem==1, go to DONE.
  - op, b and c never change in BUSY.
- DONE, while waiting for rsp_ready_i:
  - rsp_r_o = acc, rsp_cf_o = carry, rsp_of_o = ofacc.
  - rsp_zf_o = ~|acc, rsp_pf_o = acc[0], rsp_sf_o = acc[WORD_WIDTH-1].
  - On rsp_ready_i, go to IDLE.
- Requests are not accepted in BUSY or DONE; req_valid_i there is ignored and not queued.
- req_cnt_i is used unclamped. Counts above WORD_WIDTH run every step.

## Timing
- Request handshake at edge E0. BUSY occupies cycles 1..N (N = req_cnt_i). rsp_valid_o is high from cycle N+1. N=0 gives rsp_valid_o in cycle 1.
- Result and flags are held stable while rsp_valid_o=1 and rsp_ready_i=0.
- After a response handshake the block is in IDLE the next cycle, so request-to-request spacing is at least N+2 cycles.
- Reset values:
  - state=IDLE, so req_ready_o=1 and rsp_valid_o=0.
  - acc, carry, op, b, c, rem, ofacc = 0, so all rsp_* and sh_* outputs are 0 except rsp_zf_o=1.
- Reset asserted mid-BUSY or mid-DONE aborts immediately: the operation is lost, no response is produced, and all outputs take their reset values asynchronously.

## Configuration
- LEFT_SHIFT_SEQ_STICKY_OF_EN defined: in each BUSY cycle ofacc <= ofacc | sh_of_i. rsp_of_o reports overflow on any step.
- Not defined: ofacc <= sh_of_i. rsp_of_o reports the last step only.
- For N=0, rsp_of_o=0 in both builds.

## Test plan
Bench setup: WORD_WIDTH=8, with a shift-block model where op=00 gives r=a<<1, cf=a[7], of=r[7]^a[7].
- Reset: pulse rst_ni low mid-BUSY (a=0x01, cnt=5) -> outputs take reset values at once; req_ready_o=1, rsp_valid_o=0, rsp_zf_o=1; no response follows.
- Normal run: a=0x01, cf=0, cnt=3 -> rsp_valid_o in cycle 4; r=0x08, cf=0, zf=0, pf=0, sf=0, of=0.
- Zero count: a=0x80, cf=1, cnt=0 -> rsp_valid_o in cycle 1; r=0x80, cf=1, sf=1, zf=0, of=0.
- Overflow mode: a=0x60, cnt=2 -> r=0x80, cf=1, sf=1; of=1 with the macro defined, of=0 without it.
- Backpressure: hold rsp_ready_i=0 for 5 cycles while driving req_valid_i=1 -> response held constant, req_ready_o=0, second request not accepted until the cycle after the rsp handshake.
- Operand stability: op=01, b=0x5A, c=0xA5, cnt=4 -> sh_op_o/sh_b_o/sh_c_o equal 01/0x5A/0xA5 in every BUSY cycle; sh_a_o of step k equals sh_r_i of step k-1.
